// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized XNOR dense layer: run-state encoding
// and default geometry.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_IN_W    = 256;
  localparam int DEF_OUT_N   = 16;
  localparam int DEF_NUM_BLK = 4;
  localparam int DEF_T_STEPS = 30;

  // Index width that stays at least one bit for degenerate single-entry sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational population count built as a balanced binary adder tree;
// each level widens only as far as its own partial sum needs.
module bnn_popcount #(
  parameter int IN_W = 256,
  localparam int PCW = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0] bits,
  output logic [PCW-1:0]  count
);

  if (IN_W == 1) begin : g_leaf
    assign count = bits;
  end else begin : g_node
    localparam int LO_W   = IN_W / 2;
    localparam int HI_W   = IN_W - LO_W;
    localparam int LO_PCW = $clog2(LO_W + 1);
    localparam int HI_PCW = $clog2(HI_W + 1);

    logic [LO_PCW-1:0] lo_cnt;
    logic [HI_PCW-1:0] hi_cnt;

    bnn_popcount #(.IN_W(LO_W)) u_lo (.bits(bits[LO_W-1:0]),    .count(lo_cnt));
    bnn_popcount #(.IN_W(HI_W)) u_hi (.bits(bits[IN_W-1:LO_W]), .count(hi_cnt));

    assign count = PCW'(lo_cnt) + PCW'(hi_cnt);
  end

endmodule

// File: rtl/bnn_xnor_dense.sv
// Binarized dense layer: per neuron, XNOR the activation vector with a stored
// weight row, popcount the agreement and compare against a run threshold.
module bnn_xnor_dense
  import bnn_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_N   = DEF_OUT_N,
  parameter int NUM_BLK = DEF_NUM_BLK,
  parameter int T_STEPS = DEF_T_STEPS,
  localparam int BW     = idx_w(NUM_BLK),
  localparam int NW     = idx_w(OUT_N),
  localparam int PCW    = $clog2(IN_W + 1),
  localparam int SW     = $clog2(T_STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BW-1:0]    blk_sel,
  input  logic [PCW-1:0]   thr,
  input  logic             w_wr_en,
  input  logic [BW-1:0]    w_wr_blk,
  input  logic [NW-1:0]    w_wr_nrn,
  input  logic [IN_W-1:0]  w_wr_data,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_N-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  state_t          state;
  logic [IN_W-1:0] weight [NUM_BLK][OUT_N];
  logic [IN_W-1:0] w_row  [OUT_N];
  logic [BW-1:0]   blk_q;
  logic [PCW-1:0]  thr_q;
  logic [SW-1:0]   step_cnt;
  logic [SW-1:0]   acc_cnt;

  logic            vld_p1;
  logic [IN_W-1:0] x_p1  [OUT_N];
  logic [PCW-1:0]  pc_p1 [OUT_N];
  logic [OUT_N-1:0] bit_p1;
  logic            vld_p2;

  logic run_start, adv_p1, adv_p2, accept, out_fire;

  assign run_start = start && (state != ST_RUN);
  assign adv_p2    = !vld_p2 || out_ready;
  assign adv_p1    = !vld_p1 || adv_p2;
  assign in_ready  = (state == ST_RUN) && adv_p1 && (acc_cnt < SW'(T_STEPS));
  assign accept    = in_valid && in_ready;
  assign out_fire  = vld_p2 && out_ready;
  assign out_valid = vld_p2;

  // Weight rows are only writable outside a run and survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && (state != ST_RUN)) begin
      for (int b = 0; b < NUM_BLK; b++)
        for (int n = 0; n < OUT_N; n++)
          if ((w_wr_blk == BW'(b)) && (w_wr_nrn == NW'(n)))
            weight[b][n] <= w_wr_data;
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_N; j++) w_row[j] = '0;
    for (int b = 0; b < NUM_BLK; b++)
      if (blk_q == BW'(b))
        for (int j = 0; j < OUT_N; j++) w_row[j] = weight[b][j];
  end

  // Stage 1: latch run settings, register the per-neuron agreement vectors.
  always_ff @(posedge clk) begin
    if (run_start) begin
      blk_q <= blk_sel;
      thr_q <= thr;
    end
    if (accept)
      for (int j = 0; j < OUT_N; j++) x_p1[j] <= ~(in_data ^ w_row[j]);
  end

  // Stage 2 combinational front end: popcount and unsigned threshold compare.
  for (genvar j = 0; j < OUT_N; j++) begin : g_nrn
    bnn_popcount #(.IN_W(IN_W)) u_pc (.bits(x_p1[j]), .count(pc_p1[j]));
    assign bit_p1[j] = pc_p1[j] > thr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      out_data <= '0;
      step_cnt <= '0;
      acc_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            step_cnt <= '0;
            acc_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (accept) acc_cnt <= acc_cnt + SW'(1);
          if (adv_p1) vld_p1 <= accept;
          // Stage 2 register: result advances whenever the consumer can take it.
          if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) out_data <= bit_p1;
          end
          if (out_fire) begin
            if (step_cnt != SW'(T_STEPS)) step_cnt <= step_cnt + SW'(1);
            if (step_cnt == SW'(T_STEPS - 1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_xnor_dense.sv
// Bench for bnn_xnor_dense: directed runs with random activations, scored
// against an agreement-count reference model of the layer.
module tb_bnn_xnor_dense;

  localparam int IN_W    = 256;
  localparam int OUT_N   = 16;
  localparam int NUM_BLK = 4;
  localparam int T_STEPS = 30;
  localparam int BW      = 2;
  localparam int NW      = 4;
  localparam int PCW     = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [BW-1:0]    blk_sel;
  logic [PCW-1:0]   thr;
  logic             w_wr_en;
  logic [BW-1:0]    w_wr_blk;
  logic [NW-1:0]    w_wr_nrn;
  logic [IN_W-1:0]  w_wr_data;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_N-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  bnn_xnor_dense #(
    .IN_W(IN_W), .OUT_N(OUT_N), .NUM_BLK(NUM_BLK), .T_STEPS(T_STEPS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .blk_sel(blk_sel), .thr(thr),
    .w_wr_en(w_wr_en), .w_wr_blk(w_wr_blk), .w_wr_nrn(w_wr_nrn),
    .w_wr_data(w_wr_data), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [IN_W-1:0] wmod [NUM_BLK][OUT_N];
  logic [IN_W-1:0] pat;
  logic [IN_W-1:0] half;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rnd_vec();
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Neuron j fires when the number of agreeing positions exceeds the threshold.
  function automatic logic [OUT_N-1:0] ref_out(input logic [IN_W-1:0] x, input int b, input int t);
    logic [OUT_N-1:0] r;
    for (int j = 0; j < OUT_N; j++) begin
      int agree;
      agree = 0;
      for (int k = 0; k < IN_W; k++) if (x[k] == wmod[b][j][k]) agree++;
      r[j] = (agree > t);
    end
    return r;
  endfunction

  task automatic load_row(input int b, input int n, input logic [IN_W-1:0] d);
    w_wr_en   = 1'b1;
    w_wr_blk  = BW'(b);
    w_wr_nrn  = NW'(n);
    w_wr_data = d;
    @(posedge clk); #1;
    w_wr_en   = 1'b0;
    wmod[b][n] = d;
  endtask

  // dmode: 0 fixed pattern, 1 random data, 2 random data with random in_valid.
  // bpm: 0 out_ready high, 1 five-cycle stall after 10 results, 2 random out_ready.
  task automatic run(input int b, input int t, input int dmode, input int bpm, input bit poke,
                     input int rst_at, input logic [IN_W-1:0] p, input int fixed);
    logic [OUT_N-1:0] exp_q[$];
    int acc_cyc[$];
    int acc = 0, fires = 0, cyc = 0, first_acc = -1, last_fire = 0, stall_left = 0, c;
    bit extra_ok = 1'b1, stalled_prev = 1'b0, stall_done = 1'b0;
    logic [OUT_N-1:0] held, e;
    logic [IN_W-1:0] cur;
    held = '0;
    blk_sel = BW'(b);
    thr     = PCW'(t);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_state", 64'({busy, done, out_valid}), 64'(3'b100));
    cur = (dmode == 0) ? p : rnd_vec();
    while (fires < T_STEPS && cyc < 400) begin
      in_valid = (dmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = cur;
      if (bpm == 1) begin
        if (!stall_done && fires >= 10) begin
          stall_left = 5;
          stall_done = 1'b1;
        end
        out_ready = (stall_left == 0);
      end else if (bpm == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      start   = poke && (cyc == 5);
      w_wr_en = poke && (cyc == 5);
      if (poke && cyc == 5) begin
        blk_sel   = BW'((b + 1) % NUM_BLK);
        thr       = '0;
        w_wr_blk  = BW'(b);
        w_wr_nrn  = '0;
        w_wr_data = ~wmod[b][0];
      end
      #1;
      if (stalled_prev) chk("stall_hold", 64'({out_valid, out_data}), 64'({1'b1, held}));
      stalled_prev = out_valid && !out_ready;
      held = out_data;
      if (stall_left > 0) begin
        if (stall_left == 1) chk("bp_in_ready", 64'(in_ready), 64'd0);
        stall_left--;
      end
      if (in_valid && in_ready) begin
        if (acc >= T_STEPS) extra_ok = 1'b0;
        if (first_acc < 0) first_acc = cyc;
        exp_q.push_back(ref_out(cur, b, t));
        acc_cyc.push_back(cyc);
        acc++;
        cur = (dmode == 0) ? p : rnd_vec();
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
        c = (acc_cyc.size() > 0) ? acc_cyc.pop_front() : -100;
        chk("result", 64'(out_data), 64'(e));
        if (fixed >= 0) chk("fixed_result", 64'(out_data), 64'(fixed));
        if (bpm == 0) chk("latency", 64'(cyc - c), 64'd2);
        fires++;
        last_fire = cyc;
        if (fires == T_STEPS) chk("done_early", 64'(done), 64'd0);
      end
      if (rst_at >= 0 && fires == rst_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_abort", 64'({out_valid, in_ready, busy, done, out_data}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", 64'({out_valid, in_ready, busy, done, out_data}), 64'd0);
        return;
      end
      @(posedge clk); #1;
      start   = 1'b0;
      w_wr_en = 1'b0;
      cyc++;
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fires", 64'(fires), 64'(T_STEPS));
    chk("accepts", 64'(acc), 64'(T_STEPS));
    chk("no_extra_accept", 64'(extra_ok), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_state", 64'({done, busy, out_valid, in_ready}), 64'(4'b1000));
    if (dmode == 0 && bpm == 0) chk("throughput", 64'(last_fire - first_acc), 64'(T_STEPS + 1));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_hold", 64'({done, busy}), 64'(2'b10));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; blk_sel = '0; thr = '0;
    w_wr_en = 1'b0; w_wr_blk = '0; w_wr_nrn = '0; w_wr_data = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    #3;
    chk("reset_state", 64'({out_valid, in_ready, busy, done, out_data}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_state", 64'({out_valid, in_ready, busy, done, out_data}), 64'd0);

    pat  = rnd_vec();
    half = {{(IN_W/2){1'b1}}, {(IN_W/2){1'b0}}};
    for (int n = 0; n < OUT_N; n++) begin
      load_row(0, n, pat);
      load_row(2, n, ~pat);
      load_row(1, n, (n == 0) ? half : ((half << (n * 8)) | (half >> (IN_W - n * 8))));
      load_row(3, n, rnd_vec());
    end

    run(0, IN_W/2, 0, 0, 1'b0, -1, pat, 16'hFFFF);
    run(2, IN_W/2, 0, 0, 1'b0, -1, pat, 16'h0000);
    run(1, 128, 0, 0, 1'b0, -1, '0, 16'h0000);
    run(1, 127, 0, 0, 1'b0, -1, '0, 16'hFFFF);
    run(0, IN_W, 1, 0, 1'b0, -1, pat, 16'h0000);
    run(3, 124 + int'($urandom_range(0, 8)), 1, 1, 1'b1, -1, pat, -1);
    run(3, 124 + int'($urandom_range(0, 8)), 2, 2, 1'b0, -1, pat, -1);
    run(3, 128, 1, 0, 1'b0, 12, pat, -1);
    run(0, IN_W/2, 0, 0, 1'b0, -1, pat, 16'hFFFF);
    run(3, 128, 1, 2, 1'b0, -1, pat, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
